// File: rtl/current_source_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// current_source_ctrl_pkg
// Shared constants and types for the current-source DAC array controller.
//   N_THERM      : number of thermometer (unary) current units
//   N_BIN        : number of binary-weighted current units
//   CODE_W       : DAC code width
//   CODE_MAX     : largest representable code (17 * 64 + 63)
//   THERM_LSB_W  : weight of one thermometer unit in binary LSBs
//   state_t      : controller power/run state
// ---------------------------------------------------------------------------
package current_source_ctrl_pkg;

    localparam int N_THERM     = 17;
    localparam int N_BIN       = 6;
    localparam int CODE_W      = 11;
    localparam int CODE_MAX    = 1151;
    localparam int THERM_LSB_W = 64;
    localparam int PTR_W       = 5;

    localparam logic [1:0] ST_OFF_ENC     = 2'b00;
    localparam logic [1:0] ST_BIAS_UP_ENC = 2'b01;
    localparam logic [1:0] ST_ACTIVE_ENC  = 2'b10;
    localparam logic [1:0] ST_DRAIN_ENC   = 2'b11;

    typedef enum logic [1:0] {
        ST_OFF     = ST_OFF_ENC,
        ST_BIAS_UP = ST_BIAS_UP_ENC,
        ST_ACTIVE  = ST_ACTIVE_ENC,
        ST_DRAIN   = ST_DRAIN_ENC
    } state_t;

endpackage

// File: rtl/current_source_ctrl_therm_rotator.sv
// ---------------------------------------------------------------------------
// therm_rotator
// Combinational thermometer selector with wrap-around start pointer.
//   n        : number of thermometer units to enable (0..17, >=17 = all)
//   ptr      : first unit of the run (0..16)
//   mask     : enable mask, n consecutive bits starting at ptr, modulo 17
//   ptr_next : (ptr + n) modulo 17
// ---------------------------------------------------------------------------
module therm_rotator
    import current_source_ctrl_pkg::*;
(
    input  logic [PTR_W-1:0]   n,
    input  logic [PTR_W-1:0]   ptr,
    output logic [N_THERM-1:0] mask,
    output logic [PTR_W-1:0]   ptr_next
);

    logic [N_THERM:0]       one_hot;
    logic [N_THERM-1:0]     base;
    logic [2*N_THERM-1:0]   dbl;
    logic [PTR_W:0]         sum;
    logic [PTR_W:0]         sum_wrap;

    always_comb begin
        one_hot = (N_THERM+1)'(1) << n;
        if (n >= PTR_W'(N_THERM)) begin
            base = '1;
        end else begin
            base = one_hot[N_THERM-1:0] - N_THERM'(1);
        end
        // Shifting a double-width copy and folding the upper half back
        // in gives a rotate modulo 17 rather than modulo a power of two.
        dbl  = (2*N_THERM)'(base) << ptr;
        mask = dbl[N_THERM-1:0] | dbl[2*N_THERM-1:N_THERM];

        sum      = {1'b0, ptr} + {1'b0, n};
        sum_wrap = sum - (PTR_W+1)'(N_THERM);
        if (sum >= (PTR_W+1)'(N_THERM)) begin
            ptr_next = sum_wrap[PTR_W-1:0];
        end else begin
            ptr_next = sum[PTR_W-1:0];
        end
    end

endmodule

// File: rtl/current_source_ctrl.sv
// ---------------------------------------------------------------------------
// current_source_ctrl
// Power sequencing and code decode for a 17-unit thermometer + 6-bit binary
// current-source DAC array, with optional dynamic element matching and a
// redundant LSB unit.
//   clk, rst_n             : clock, asynchronous active-low reset
//   enable                 : level request to power and run the array
//   code_valid/code_ready  : code handshake, code is 11-bit unsigned
//   dem_en, red_en         : DEM rotation / redundant LSB steering
//   atb_sel / atb_ena      : testbus select request / registered enable
//   pdb                    : power-down-bar to the array
//   them_en, bin_en        : unit enables, bin0_red_en redundant LSB enable
//   active                 : controller in ACTIVE state
//   sat                    : pulse when the displayed code was clipped
// ---------------------------------------------------------------------------
module current_source_ctrl
    import current_source_ctrl_pkg::*;
#(
    parameter int SETTLE_CYCLES = 64,
    parameter int DRAIN_CYCLES  = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic               code_valid,
    input  logic [CODE_W-1:0]  code,
    output logic               code_ready,
    input  logic               dem_en,
    input  logic               red_en,
    input  logic [1:0]         atb_sel,
    output logic               pdb,
    output logic [N_THERM-1:0] them_en,
    output logic [N_BIN-1:0]   bin_en,
    output logic               bin0_red_en,
    output logic [1:0]         atb_ena,
    output logic               active,
    output logic               sat
);

    localparam int CNT_MAX = (SETTLE_CYCLES > DRAIN_CYCLES) ? SETTLE_CYCLES : DRAIN_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    function automatic logic [CODE_W-1:0] sat_code(input logic [CODE_W-1:0] c);
        return (c > CODE_W'(CODE_MAX)) ? CODE_W'(CODE_MAX) : c;
    endfunction

    function automatic logic is_clipped(input logic [CODE_W-1:0] c);
        return (c > CODE_W'(CODE_MAX));
    endfunction

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PTR_W-1:0]   ptr_q;
    logic               xfer;

    logic [CODE_W-1:0]  code_p0;
    logic               clip_p0;
    logic [PTR_W-1:0]   n_p0;
    logic [PTR_W-1:0]   rot_ptr_p0;
    logic [N_THERM-1:0] mask_p0;
    logic [PTR_W-1:0]   ptr_next_p0;

    logic [N_THERM-1:0] them_en_p1;
    logic [N_BIN-1:0]   bin_en_p1;
    logic               red_p1;
    logic               sat_p1;
    logic [1:0]         atb_p1;

    // ---- control: power sequencing FSM ----
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_OFF: begin
                cnt_d = '0;
                if (enable) begin
                    state_d = ST_BIAS_UP;
                    cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
                end
            end
            ST_BIAS_UP: begin
                if (!enable) begin
                    state_d = ST_DRAIN;
                    cnt_d   = CNT_W'(DRAIN_CYCLES - 1);
                end else if (cnt_q == '0) begin
                    state_d = ST_ACTIVE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_ACTIVE: begin
                if (!enable) begin
                    state_d = ST_DRAIN;
                    cnt_d   = CNT_W'(DRAIN_CYCLES - 1);
                end
            end
            ST_DRAIN: begin
                // enable is deliberately ignored until the array is fully off
                if (cnt_q == '0) begin
                    state_d = ST_OFF;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_OFF;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_OFF;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign code_ready = (state_q == ST_ACTIVE) && enable;
    assign xfer       = code_ready && code_valid;

    // ---- stage p0: clip and decode the offered code ----
    assign code_p0    = sat_code(code);
    assign clip_p0    = is_clipped(code);
    assign n_p0       = code_p0[CODE_W-1:N_BIN];
    // Without DEM the run always starts at unit 0.
    assign rot_ptr_p0 = dem_en ? ptr_q : '0;

    therm_rotator u_therm_rotator (
        .n        (n_p0),
        .ptr      (rot_ptr_p0),
        .mask     (mask_p0),
        .ptr_next (ptr_next_p0)
    );

    // ---- stage p1: registered unit enables ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            them_en_p1 <= '0;
            bin_en_p1  <= '0;
            red_p1     <= 1'b0;
            sat_p1     <= 1'b0;
        end else if (state_d != ST_ACTIVE) begin
            // Leaving ACTIVE (or never in it): array carries zero current.
            them_en_p1 <= '0;
            bin_en_p1  <= '0;
            red_p1     <= 1'b0;
            sat_p1     <= 1'b0;
        end else if (xfer) begin
            them_en_p1 <= mask_p0;
            bin_en_p1  <= red_en ? {code_p0[N_BIN-1:1], 1'b0} : code_p0[N_BIN-1:0];
            red_p1     <= red_en & code_p0[0];
            sat_p1     <= clip_p0;
        end else begin
            sat_p1     <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else if (state_d == ST_OFF) begin
            ptr_q <= '0;
        end else if (xfer && dem_en) begin
            ptr_q <= ptr_next_p0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            atb_p1 <= 2'b00;
        end else begin
            atb_p1 <= atb_sel;
        end
    end

    assign pdb         = (state_q != ST_OFF);
    assign active      = (state_q == ST_ACTIVE);
    assign atb_ena     = (state_q == ST_OFF) ? 2'b00 : atb_p1;
    assign them_en     = them_en_p1;
    assign bin_en      = bin_en_p1;
    assign bin0_red_en = red_p1;
    assign sat         = sat_p1;

endmodule

// File: tb/tb_current_source_ctrl.sv
module tb_current_source_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        code_valid = 1'b0;
    logic [10:0] code = '0;
    logic        code_ready;
    logic        dem_en = 1'b0;
    logic        red_en = 1'b0;
    logic [1:0]  atb_sel = 2'b10;
    logic        pdb;
    logic [16:0] them_en;
    logic [5:0]  bin_en;
    logic        bin0_red_en;
    logic [1:0]  atb_ena;
    logic        active;
    logic        sat;

    int total = 0;
    int bad   = 0;
    int mp    = 0;   // bench model of the DEM pointer

    typedef struct {
        logic [16:0] them;
        logic [5:0]  bin;
        logic        red;
        logic        sat;
        int          clipped;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    current_source_ctrl #(.SETTLE_CYCLES(64), .DRAIN_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .code_valid(code_valid),
        .code(code), .code_ready(code_ready), .dem_en(dem_en), .red_en(red_en),
        .atb_sel(atb_sel), .pdb(pdb), .them_en(them_en), .bin_en(bin_en),
        .bin0_red_en(bin0_red_en), .atb_ena(atb_ena), .active(active), .sat(sat)
    );

    // Build the expected outputs for one accepted code and push them.
    task automatic push_expect(input int c, input bit dem, input bit red);
        exp_t e;
        int   cl, n, start;
        cl = (c > 1151) ? 1151 : c;
        n  = cl / 64;
        start = dem ? mp : 0;
        e.them = '0;
        for (int i = 0; i < n; i++) e.them[(start + i) % 17] = 1'b1;
        e.bin = 6'(cl % 64);
        if (red) e.bin[0] = 1'b0;
        e.red = red && (cl % 2 == 1);
        e.sat = (c > 1151);
        e.clipped = cl;
        if (dem) mp = (mp + n) % 17;
        sb.push_back(e);
    endtask

    // Offer one code in ACTIVE; called at posedge+1, returns at posedge+1.
    task automatic send(input int c, input bit dem, input bit red);
        exp_t e;
        int   weight;
        code_valid = 1'b1;
        code = 11'(c);
        dem_en = dem;
        red_en = red;
        push_expect(c, dem, red);
        #1;
        total++;
        if (code_ready !== 1'b1) begin
            bad++; $display("FAIL ready_before_xfer code=%0d actual=%b required=1", c, code_ready);
        end
        @(posedge clk); #1;
        code_valid = 1'b0;
        e = sb.pop_front();
        total++;
        if (them_en !== e.them || bin_en !== e.bin || bin0_red_en !== e.red || sat !== e.sat) begin
            bad++;
            $display("FAIL decode code=%0d actual them=%h bin=%h red=%b sat=%b required them=%h bin=%h red=%b sat=%b",
                     c, them_en, bin_en, bin0_red_en, sat, e.them, e.bin, e.red, e.sat);
        end
        weight = $countones(them_en) * 64 + int'(bin_en) + int'(bin0_red_en);
        total++;
        if (active !== 1'b1 || weight != e.clipped) begin
            bad++; $display("FAIL weight code=%0d actual=%0d active=%b required=%0d", c, weight, active, e.clipped);
        end
    endtask

    // From OFF with enable about to be high: count settle time to ACTIVE.
    task automatic bring_up();
        int cnt = 0;
        enable = 1'b1;
        @(posedge clk); #1;
        total++;
        if (pdb !== 1'b1 || active !== 1'b0 || atb_ena !== atb_sel) begin
            bad++; $display("FAIL bias_entry actual pdb=%b active=%b atb=%b required pdb=1 active=0 atb=%b",
                            pdb, active, atb_ena, atb_sel);
        end
        while (active !== 1'b1 && cnt < 200) begin
            @(posedge clk); #1;
            cnt++;
        end
        total++;
        if (cnt != 64) begin
            bad++; $display("FAIL settle_cycles actual=%0d required=64", cnt);
        end
        total++;
        if (code_ready !== 1'b1 || them_en !== 17'h0) begin
            bad++; $display("FAIL active_entry actual ready=%b them=%h required ready=1 them=0", code_ready, them_en);
        end
    endtask

    task automatic test_reset();
        #1;
        total++;
        if (pdb !== 1'b0 || them_en !== '0 || bin_en !== '0 || bin0_red_en !== 1'b0 ||
            atb_ena !== 2'b00 || active !== 1'b0 || sat !== 1'b0 || code_ready !== 1'b0) begin
            bad++; $display("FAIL reset_state actual pdb=%b them=%h bin=%h red=%b atb=%b act=%b sat=%b rdy=%b required all 0",
                            pdb, them_en, bin_en, bin0_red_en, atb_ena, active, sat, code_ready);
        end
        #11 rst_n = 1'b1;
        mp = 0;
        @(posedge clk); #1;
        total++;
        if (pdb !== 1'b0) begin
            bad++; $display("FAIL idle_off actual pdb=%b required 0", pdb);
        end
        bring_up();
    endtask

    task automatic test_decode();
        send(200, 1'b0, 1'b0);
        total++;
        if (them_en !== 17'h00007 || bin_en !== 6'b001000 || sat !== 1'b0) begin
            bad++; $display("FAIL code200 actual them=%h bin=%h sat=%b required them=00007 bin=08 sat=0", them_en, bin_en, sat);
        end
    endtask

    task automatic test_dem();
        logic [16:0] req [4];
        req[0] = 17'h003FF; req[1] = 17'h1FC07; req[2] = 17'h01FF8; req[3] = 17'h02000;
        for (int i = 0; i < 4; i++) begin
            send((i == 3) ? 64 : 640, 1'b1, 1'b0);
            total++;
            if (them_en !== req[i]) begin
                bad++; $display("FAIL dem_mask step=%0d actual=%h required=%h", i, them_en, req[i]);
            end
        end
    endtask

    task automatic test_sat();
        send(2047, 1'b0, 1'b0);
        total++;
        if (them_en !== 17'h1FFFF || bin_en !== 6'h3F || sat !== 1'b1) begin
            bad++; $display("FAIL clip actual them=%h bin=%h sat=%b required 1ffff 3f 1", them_en, bin_en, sat);
        end
        @(posedge clk); #1;
        total++;
        if (sat !== 1'b0 || them_en !== 17'h1FFFF) begin
            bad++; $display("FAIL sat_pulse actual sat=%b them=%h required sat=0 them=1ffff", sat, them_en);
        end
        send(1152, 1'b0, 1'b0);
        send(1151, 1'b0, 1'b0);
    endtask

    task automatic test_red();
        send(1, 1'b0, 1'b1);
        total++;
        if (bin_en !== 6'h00 || bin0_red_en !== 1'b1) begin
            bad++; $display("FAIL redundant actual bin=%h red=%b required bin=00 red=1", bin_en, bin0_red_en);
        end
        send(3, 1'b0, 1'b1);
        send(3, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 10; i++) begin
            send(int'($urandom_range(0, 2047)), bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
        end
        total++;
        if (sb.size() != 0) begin
            bad++; $display("FAIL scoreboard_left actual=%0d required=0", sb.size());
        end
    endtask

    task automatic test_drain();
        enable = 1'b0;
        code_valid = 1'b1;
        code = 11'd500;
        #1;
        total++;
        if (code_ready !== 1'b0) begin
            bad++; $display("FAIL ready_on_disable actual=%b required=0", code_ready);
        end
        @(posedge clk); #1;
        code_valid = 1'b0;
        enable = 1'b1;   // re-assert while draining; must be ignored
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin @(posedge clk); #1; end
            total++;
            if (pdb !== 1'b1 || them_en !== '0 || bin_en !== '0 || active !== 1'b0) begin
                bad++; $display("FAIL drain cyc=%0d actual pdb=%b them=%h bin=%h act=%b required pdb=1 rest 0",
                                i, pdb, them_en, bin_en, active);
            end
        end
        @(posedge clk); #1;
        mp = 0;
        total++;
        if (pdb !== 1'b0 || atb_ena !== 2'b00 || active !== 1'b0) begin
            bad++; $display("FAIL drain_done actual pdb=%b atb=%b act=%b required 0 00 0", pdb, atb_ena, active);
        end
        bring_up();
    endtask

    task automatic test_reset_mid();
        send(700, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (pdb !== 1'b0 || them_en !== '0 || bin_en !== '0 || active !== 1'b0 || atb_ena !== 2'b00 || code_ready !== 1'b0) begin
            bad++; $display("FAIL reset_active actual pdb=%b them=%h bin=%h act=%b atb=%b rdy=%b required all 0",
                            pdb, them_en, bin_en, active, atb_ena, code_ready);
        end
        #2 rst_n = 1'b1;
        mp = 0;
        enable = 1'b1;
        @(posedge clk); #1;
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (pdb !== 1'b0 || active !== 1'b0 || atb_ena !== 2'b00) begin
            bad++; $display("FAIL reset_bias actual pdb=%b act=%b atb=%b required 0 0 00", pdb, active, atb_ena);
        end
        #2 rst_n = 1'b1;
        bring_up();
        send(640, 1'b1, 1'b0);
        total++;
        if (them_en !== 17'h003FF) begin
            bad++; $display("FAIL ptr_after_reset actual=%h required=003ff", them_en);
        end
    endtask

    initial begin
        test_reset();
        test_decode();
        test_dem();
        test_sat();
        test_red();
        test_back_to_back();
        test_drain();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
